// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared constants and fill-state encoding for the
//                instruction-cache line-fill responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int ADDR_W     = 10;                  // 1024-word program RAM
    localparam int DATA_W     = 32;                  // instruction word
    localparam int LINE_WORDS = 8;                   // words per cache line
    localparam int OFFS_W     = $clog2(LINE_WORDS);  // word offset within a line

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rsp_fifo
//  Description : Two-entry response buffer holding {last,index,data} words
//                returned from program RAM until the cache accepts them.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsp_fifo
    import proc_pkg::*;
#(
    parameter int WIDTH = 1 + OFFS_W + DATA_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Storage, pointers and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/line_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_responder
//  Description : Serves one instruction-cache line refill at a time: reads the
//                line from synchronous program RAM critical-word-first and
//                streams the words back under valid/ready backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fill_responder #(
    parameter int ADDR_W     = proc_pkg::ADDR_W,
    parameter int DATA_W     = proc_pkg::DATA_W,
    parameter int LINE_WORDS = proc_pkg::LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [$clog2(LINE_WORDS)-1:0] rsp_index,
    output logic                          rsp_last
);

    import proc_pkg::*;

    localparam int c_OFFS_W    = $clog2(LINE_WORDS);
    localparam int c_LINE_W    = ADDR_W - c_OFFS_W;
    localparam int c_PAYLOAD_W = 1 + c_OFFS_W + DATA_W;

    fill_state_t            r_state;
    fill_state_t            w_next_state;
    logic [c_LINE_W-1:0]    r_line;          // line base, offset bits dropped
    logic [c_OFFS_W-1:0]    r_offs;          // offset of the next word to read
    logic [c_OFFS_W-1:0]    r_issue_cnt;     // reads issued so far in this line
    logic                   r_inflight;      // RAM data arrives this cycle
    logic [c_OFFS_W-1:0]    r_inflight_offs;
    logic                   r_inflight_last;
    logic                   w_issue;
    logic                   w_pop;
    logic                   w_last_issue;
    logic                   w_head_last;
    logic [1:0]             w_fifo_count;
    logic [2:0]             w_level;
    logic [c_PAYLOAD_W-1:0] w_head;

    assign req_ready    = (r_state == IDLE);
    assign w_pop        = rsp_valid && rsp_ready;
    assign w_last_issue = (r_issue_cnt == c_OFFS_W'(LINE_WORDS - 1));
    assign w_head_last  = w_head[c_PAYLOAD_W-1];

    // Words buffered plus the one in flight, net of this cycle's pop: a read
    // is only launched when the FIFO is guaranteed a free slot for its data.
    assign w_level = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);

    // Fill-state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and RAM read strobe.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_issue = (w_level < 3'd2);
                if (w_issue && w_last_issue) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign mem_rd_en = w_issue;
    // Offset wraps inside the line, so the address never leaves its line.
    assign mem_addr  = w_issue ? {r_line, r_offs} : '0;

    // Request capture, wrapping offset counter and in-flight read tracking.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_line          <= '0;
            r_offs          <= '0;
            r_issue_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_offs <= '0;
            r_inflight_last <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                r_line      <= req_addr[ADDR_W-1:c_OFFS_W];
                r_offs      <= req_addr[c_OFFS_W-1:0];
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_offs      <= r_offs + c_OFFS_W'(1);
                r_issue_cnt <= r_issue_cnt + c_OFFS_W'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_offs <= r_offs;
            r_inflight_last <= w_last_issue;
        end
    end

    rsp_fifo #(
        .WIDTH (c_PAYLOAD_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .push      (r_inflight),
        .push_data ({r_inflight_last, r_inflight_offs, mem_rdata}),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_count)
    );

    assign rsp_valid = (w_fifo_count != 2'd0);
    assign rsp_data  = w_head[DATA_W-1:0];
    assign rsp_index = w_head[DATA_W +: c_OFFS_W];
    assign rsp_last  = rsp_valid && w_head_last;

endmodule
`default_nettype wire

// File: tb/tb_line_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_fill_responder
//  Description : Self-checking bench for line_fill_responder with a RAM model
//                and a critical-word-first line reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_responder;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_index;
    logic        rsp_last;

    logic [31:0] ram [1024];
    int          total = 0;
    int          bad   = 0;
    int          cyc_cnt = 0;

    line_fill_responder dut (
        .clk       (clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_index (rsp_index),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Synchronous single-port program RAM: data one cycle after the strobe.
    always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_last",  rsp_last,  0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_rsp_data",  rsp_data,  0);
        chk("rst_rsp_index", rsp_index, 0);
    endtask

    // One line fill. mode: 0 ready always, 1 ready 1,0,0 repeating, 2 random.
    // abort>0 resets the DUT right after that many words have been popped.
    task automatic fill(input logic [9:0] addr, input int mode, input int abort,
                        input bit hold_next, input logic [9:0] next_addr, input bit timing);
        logic [9:0]  exp_a [8];
        logic [31:0] exp_d [8];
        logic [2:0]  exp_i [8];
        int          a, b, off, pi, pp, acc, waitc;
        bit          done, aborted, prev_stall, seen_first;
        logic [31:0] pd;
        logic [2:0]  px;
        logic        pl;

        // Reference line: critical word first, wrapping inside the aligned line.
        a = int'(addr);
        b = a - (a % 8);
        for (int k = 0; k < 8; k++) begin
            off      = (a + k) % 8;
            exp_a[k] = 10'(b + off);
            exp_d[k] = ram[b + off];
            exp_i[k] = 3'(off);
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        chk("accept_wait", waitc, 0);
        chk("req_ready_idle", req_ready, 1);
        chk("rsp_valid_idle", rsp_valid, 0);

        @(posedge clk);
        #1;
        acc = cyc_cnt;
        if (hold_next) req_addr = next_addr;
        else           req_valid = 1'b0;

        pi = 0; pp = 0; done = 0; aborted = 0; prev_stall = 0; seen_first = 0;
        pd = '0; px = '0; pl = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = (k % 3 == 0);
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("req_ready_busy", req_ready, 0);
            if (prev_stall) begin
                chk("stall_valid", rsp_valid, 1);
                chk("stall_data",  rsp_data,  pd);
                chk("stall_index", rsp_index, px);
                chk("stall_last",  rsp_last,  pl);
            end
            if (rsp_valid) begin
                if (!seen_first) begin
                    seen_first = 1;
                    if (timing) chk("first_latency", cyc_cnt - acc, 2);
                end
                if (pp < 8) begin
                    chk("rsp_data",  rsp_data,  exp_d[pp]);
                    chk("rsp_index", rsp_index, exp_i[pp]);
                    chk("rsp_last",  rsp_last,  (pp == 7));
                end else begin
                    chk("extra_word", pp, 7);
                end
                if (rsp_last && timing) chk("last_latency", cyc_cnt - acc, 9);
                prev_stall = !rsp_ready;
                pd = rsp_data; px = rsp_index; pl = rsp_last;
                if (rsp_ready) pp++;
            end else begin
                chk("idle_last", rsp_last, 0);
                prev_stall = 0;
            end
            if (mem_rd_en) begin
                if (pi < 8) chk("mem_addr", mem_addr, exp_a[pi]);
                else        chk("extra_read", pi, 7);
                pi++;
            end
            chk("outstanding", (pi - pp) <= 2, 1);
            if (pp == 8) done = 1;
            if (abort > 0 && pp == abort) begin
                aborted = 1;
                done    = 1;
            end
        end
        if (!done) chk("fill_timeout", pp, 8);

        @(posedge clk);
        if (aborted) begin
            #1;
            Reset = 1'b0;
            #1;
            chk_reset_outputs();
            @(negedge clk);
            Reset     = 1'b1;
            rsp_ready = 1'b0;
        end else begin
            chk("issue_total", pi, 8);
        end
    endtask

    initial begin
        Reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = (i < 64) ? 32'(i) * 32'h1111_1111 : $urandom;
        end

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        Reset = 1'b1;

        fill(10'h000, 0, 0, 0, 10'h000, 1);   // aligned, full throughput
        fill(10'h00D, 0, 0, 0, 10'h000, 1);   // critical word first
        fill(10'h040, 1, 0, 0, 10'h000, 0);   // backpressure
        fill(10'h3FF, 0, 0, 0, 10'h000, 1);   // top of memory
        fill(10'h008, 2, 3, 0, 10'h000, 0);   // reset after 3rd pop
        fill(10'h010, 0, 0, 0, 10'h000, 1);   // clean line after reset
        fill(10'h020, 0, 0, 1, 10'h1A5, 1);   // back-to-back, second held
        fill(10'h1A5, 2, 0, 0, 10'h000, 0);
        for (int r = 0; r < 6; r++) begin
            fill(10'($urandom_range(0, 1023)), 2, 0, 0, 10'h000, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
